// File: rtl/tuner_nco.sv
// -----------------------------------------------------------------------------
// tuner_nco
//
// Numerically controlled oscillator that produces the phase word for a tuner
// mixer. A phase accumulator advances by the frequency word on each sample
// strobe. A phase offset and an optional LFSR dither are then added, and the
// result is truncated to the mixer phase width.
//
// Configuration is double-buffered. A write lands in a shadow register and
// raises that target's pending flag. The next sample strobe copies the shadow
// value into the active register. A second write to the same target is held
// off through cfg_ready until then, so no written value is ever lost.
//
// Pipeline (one sample per en, back-to-back capable):
//   en cycle  : accumulator update, carry capture, offset/dither capture
//   en + 1    : offset + dither add, truncation, output registers
//   en + 2    : phs / phs_valid / wrap visible
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   en         sample strobe
//   cfg_valid  configuration write request
//   cfg_sel    write target: 0 = frequency word, 1 = phase offset
//   cfg_data   write data (phase offset uses the low PSZ bits)
//   cfg_ready  write accepted when cfg_valid & cfg_ready
//   sync_clr   zero the accumulator at the next strobe
//   dither_en  add LFSR dither below the output LSB
//   phs        output phase word (held between valid samples)
//   phs_valid  one-cycle qualifier for phs
//   wrap       accumulator overflow marker, aligned with phs_valid
// -----------------------------------------------------------------------------
module tuner_nco #(
   parameter int ASZ = 32,
   parameter int PSZ = 11
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           en,
   input  logic           cfg_valid,
   input  logic           cfg_sel,
   input  logic [ASZ-1:0] cfg_data,
   output logic           cfg_ready,
   input  logic           sync_clr,
   input  logic           dither_en,
   output logic [PSZ-1:0] phs,
   output logic           phs_valid,
   output logic           wrap
);

   // Dither spans every accumulator bit below the output LSB.
   localparam int          DW        = ASZ - PSZ;
   localparam int          DL        = (DW < 32) ? DW : 32;
   localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

   // Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], fb};
   endfunction

   // Plain truncation to the mixer phase width; dither replaces rounding.
   function automatic logic [PSZ-1:0] trunc_phase(input logic [ASZ-1:0] s);
      return s[ASZ-1 -: PSZ];
   endfunction

   // Configuration state
   logic [ASZ-1:0] freq;
   logic [ASZ-1:0] freq_shadow;
   logic           freq_pend;
   logic [PSZ-1:0] poff;
   logic [PSZ-1:0] poff_shadow;
   logic           poff_pend;
   logic           cfg_hs;

   // Accumulator and dither source
   logic [ASZ-1:0] acc;
   logic [ASZ:0]   acc_sum;
   logic           sync_clr_pend;
   logic           clr_now;
   logic [31:0]    lfsr;
   logic [DW-1:0]  dith_bits;

   // Stage-1 outputs
   logic           vld_p1;
   logic           carry_p1;
   logic [PSZ-1:0] poff_p1;
   logic [DW-1:0]  dith_p1;

   // Stage-2 arithmetic
   logic [ASZ-1:0] sum_p2;

   // Ready only depends on the addressed target's pending flag.
   assign cfg_ready = cfg_sel ? ~poff_pend : ~freq_pend;
   assign cfg_hs    = cfg_valid & cfg_ready;

   // A sync_clr arriving on the strobe itself clears on that strobe.
   assign clr_now   = sync_clr_pend | sync_clr;
   assign acc_sum   = {1'b0, acc} + {1'b0, freq};

   always_comb begin
      dith_bits         = '0;
      dith_bits[DL-1:0] = lfsr[DL-1:0];
   end

   // ---------------------------------------------------------------------
   // Configuration shadows: apply pending values on en, then capture new
   // writes. A write cannot hit a target that is applying this cycle,
   // because that target's pending flag holds cfg_ready low.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         freq        <= '0;
         freq_shadow <= '0;
         freq_pend   <= 1'b0;
         poff        <= '0;
         poff_shadow <= '0;
         poff_pend   <= 1'b0;
      end else begin
         if (en) begin
            if (freq_pend) begin
               freq      <= freq_shadow;
               freq_pend <= 1'b0;
            end
            if (poff_pend) begin
               poff      <= poff_shadow;
               poff_pend <= 1'b0;
            end
         end
         if (cfg_hs) begin
            if (cfg_sel) begin
               poff_shadow <= cfg_data[PSZ-1:0];
               poff_pend   <= 1'b1;
            end else begin
               freq_shadow <= cfg_data;
               freq_pend   <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 1 (en cycle): accumulate, capture carry, offset and dither.
   // The offset and dither are captured before any update on this strobe,
   // so a newly applied offset affects only later samples.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc           <= '0;
         sync_clr_pend <= 1'b0;
         lfsr          <= LFSR_SEED;
         vld_p1        <= 1'b0;
         carry_p1      <= 1'b0;
         poff_p1       <= '0;
         dith_p1       <= '0;
      end else begin
         vld_p1 <= en;
         if (en) begin
            acc           <= clr_now ? '0 : acc_sum[ASZ-1:0];
            carry_p1      <= ~clr_now & acc_sum[ASZ];
            poff_p1       <= poff;
            dith_p1       <= dither_en ? dith_bits : '0;
            sync_clr_pend <= 1'b0;
            // The all-zero lock-up state is unreachable from the seed.
            // Reloading the seed only guards against a corrupted register.
            lfsr          <= (lfsr == 32'd0) ? LFSR_SEED : lfsr_next(lfsr);
         end else if (sync_clr) begin
            sync_clr_pend <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 (en + 1): offset and dither add, truncate, register outputs.
   // acc still holds the value written by the strobe being processed,
   // even if another strobe updates acc at this same edge.
   // ---------------------------------------------------------------------
   assign sum_p2 = acc + {poff_p1, {DW{1'b0}}} + {{PSZ{1'b0}}, dith_p1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phs       <= '0;
         phs_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         phs_valid <= vld_p1;
         wrap      <= vld_p1 & carry_p1;
         if (vld_p1) begin
            phs <= trunc_phase(sum_p2);
         end
      end
   end

endmodule

// File: tb/tb_tuner_nco.sv
module tb_tuner_nco;

   localparam int ASZ = 32;
   localparam int PSZ = 11;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           en;
   logic           cfg_valid;
   logic           cfg_sel;
   logic [ASZ-1:0] cfg_data;
   logic           cfg_ready;
   logic           sync_clr;
   logic           dither_en;
   logic [PSZ-1:0] phs;
   logic           phs_valid;
   logic           wrap;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tuner_nco #(.ASZ(ASZ), .PSZ(PSZ)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_sel   (cfg_sel),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .sync_clr  (sync_clr),
      .dither_en (dither_en),
      .phs       (phs),
      .phs_valid (phs_valid),
      .wrap      (wrap)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (per-sample arithmetic) ----------------
   bit [31:0] m_freq, m_shf, m_acc, m_lfsr;
   bit [10:0] m_poff, m_shp;
   bit        m_pf, m_pp, m_clr;
   bit        mid_v, mid_w;
   bit [10:0] mid_p;
   bit        e_v, e_w;
   bit [10:0] e_p;
   bit [10:0] obs_p[$];
   bit        obs_w[$];

   function automatic bit [31:0] lfsr_step(input bit [31:0] s);
      bit fb;
      fb = ^(s & 32'h8020_0003);
      return (s << 1) | {31'b0, fb};
   endfunction

   task automatic model_reset();
      m_freq = 0; m_shf = 0; m_acc = 0; m_lfsr = 32'hACE1_0001;
      m_poff = 0; m_shp = 0; m_pf = 0; m_pp = 0; m_clr = 0;
      mid_v = 0; mid_w = 0; mid_p = 0; e_v = 0; e_w = 0; e_p = 0;
   endtask

   task automatic model_edge();
      bit        hs, clr;
      bit [32:0] sum;
      bit [31:0] nacc, d, s;
      if (!reset_n) begin
         model_reset();
         return;
      end
      hs  = cfg_valid && !(cfg_sel ? m_pp : m_pf);
      e_v = mid_v;
      e_w = mid_v && mid_w;
      if (mid_v) e_p = mid_p;
      mid_v = en;
      if (en) begin
         clr   = m_clr || sync_clr;
         sum   = {1'b0, m_acc} + {1'b0, m_freq};
         nacc  = clr ? 32'd0 : sum[31:0];
         mid_w = !clr && sum[32];
         d     = dither_en ? (m_lfsr & 32'h001F_FFFF) : 32'd0;
         s     = nacc + ({21'b0, m_poff} << 21) + d;
         mid_p = s[31:21];
         m_acc  = nacc;
         m_clr  = 0;
         m_lfsr = lfsr_step(m_lfsr);
         if (m_pf) begin m_freq = m_shf; m_pf = 0; end
         if (m_pp) begin m_poff = m_shp; m_pp = 0; end
      end else if (sync_clr) begin
         m_clr = 1;
      end
      if (hs) begin
         if (cfg_sel) begin m_shp = cfg_data[10:0]; m_pp = 1; end
         else         begin m_shf = cfg_data;       m_pf = 1; end
      end
   endtask

   // One clock: check ready before the edge, outputs after it.
   task automatic tick();
      #1;
      check("cfg_ready", cfg_ready, !(cfg_sel ? m_pp : m_pf));
      @(posedge clk);
      model_edge();
      #1;
      check("phs_valid", phs_valid, e_v);
      check("wrap", wrap, e_w);
      check("phs", phs, e_p);
      if (phs_valid) begin
         obs_p.push_back(phs);
         obs_w.push_back(wrap);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_phs"}, phs, 0);
      check({tag, "_valid"}, phs_valid, 0);
      check({tag, "_wrap"}, wrap, 0);
      check({tag, "_ready"}, cfg_ready, 1);
   endtask

   task automatic do_reset();
      reset_n = 0; en = 0; cfg_valid = 0; cfg_sel = 0; cfg_data = 0;
      sync_clr = 0; dither_en = 0;
      model_reset();
      #1;
      check_reset_outputs("rst");
      tick();
      tick();
      reset_n = 1;
   endtask

   task automatic write_cfg(input bit sel, input bit [31:0] data);
      cfg_valid = 1; cfg_sel = sel; cfg_data = data;
      tick();
      cfg_valid = 0;
   endtask

   initial begin
      bit [10:0] exp43 [10];
      int n_jump, n_bad;
      bit ok;

      reset_n = 1; en = 0; cfg_valid = 0; cfg_sel = 0; cfg_data = 0;
      sync_clr = 0; dither_en = 0;
      model_reset();
      #2;
      do_reset();

      // Ramp: freq = 1/8 turn gives 0x000..0x700 then wraps.
      obs_p.delete(); obs_w.delete();
      write_cfg(0, 32'h2000_0000);
      en = 1;
      repeat (12) tick();
      for (int i = 0; i < 8; i++) exp43[i] = 11'(i * 'h100);
      exp43[8] = 11'h000; exp43[9] = 11'h100;
      check("seq43_count", obs_p.size() >= 10, 1);
      for (int i = 0; i < 10 && i < obs_p.size(); i++) begin
         check($sformatf("seq43_phs[%0d]", i), obs_p[i], exp43[i]);
         check($sformatf("seq43_wrap[%0d]", i), obs_w[i], (i == 8));
      end

      // Mid-stream offset write: exactly one step of 0x300, all others 0x100.
      obs_p.delete(); obs_w.delete();
      write_cfg(1, 32'h0000_0200);
      repeat (6) tick();
      en = 0;
      tick(); tick();
      n_jump = 0; n_bad = 0;
      for (int i = 1; i < obs_p.size(); i++) begin
         if (11'(obs_p[i] - obs_p[i-1]) == 11'h300) n_jump++;
         else if (11'(obs_p[i] - obs_p[i-1]) != 11'h100) n_bad++;
      end
      check("poff_jump_count", n_jump, 1);
      check("poff_bad_steps", n_bad, 0);

      // Stalled second frequency write.
      cfg_valid = 1; cfg_sel = 0; cfg_data = 32'h1000_0000;
      tick();
      cfg_data = 32'h0400_0000;
      #1 check("stall_ready", cfg_ready, 0);
      tick(); tick();
      en = 1;
      tick();
      en = 0;
      #1 check("ready_after_apply", cfg_ready, 1);
      tick();
      cfg_valid = 0;
      #1 check("second_pending", cfg_ready, 0);
      en = 1;
      repeat (4) tick();
      en = 0;
      tick(); tick();

      // sync_clr while idle: next samples restart from zero without wrap.
      do_reset();
      write_cfg(0, 32'h1000_0000);
      en = 1;
      repeat (5) tick();
      en = 0;
      tick(); tick();
      obs_p.delete(); obs_w.delete();
      sync_clr = 1;
      tick();
      sync_clr = 0;
      tick();
      en = 1;
      repeat (3) tick();
      en = 0;
      tick(); tick();
      check("clr_count", obs_p.size(), 3);
      if (obs_p.size() == 3) begin
         check("clr_phs0", obs_p[0], 11'h000);
         check("clr_wrap0", obs_w[0], 0);
         check("clr_phs1", obs_p[1], 11'h080);
         check("clr_phs2", obs_p[2], 11'h100);
      end

      // Dither on a static phase stays within one LSB of zero.
      do_reset();
      obs_p.delete(); obs_w.delete();
      dither_en = 1;
      for (int i = 0; i < 150; i++) begin
         en = ($urandom_range(0, 3) != 0);
         tick();
      end
      en = 0;
      tick(); tick();
      dither_en = 0;
      check("dither_seen", obs_p.size() > 50, 1);
      foreach (obs_p[i]) begin
         ok = (obs_p[i] == 11'h000) || (obs_p[i] == 11'h001) || (obs_p[i] == 11'h7FF);
         check("dither_range", ok, 1);
      end

      // Asynchronous reset mid-stream with a write pending.
      do_reset();
      write_cfg(0, 32'h2000_0000);
      en = 1;
      repeat (5) tick();
      cfg_valid = 1; cfg_sel = 0; cfg_data = 32'h4000_0000;
      tick();
      cfg_valid = 0;
      check("pre_reset_valid", phs_valid, 1);
      reset_n = 0;
      model_reset();
      #1;
      check_reset_outputs("async_rst");
      tick();
      reset_n = 1;
      obs_p.delete(); obs_w.delete();
      repeat (8) tick();
      check("post_reset_count", obs_p.size(), 7);
      foreach (obs_p[i]) check("post_reset_phs", obs_p[i], 11'h000);
      en = 0;

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         en        = ($urandom_range(0, 3) != 0);
         cfg_valid = ($urandom_range(0, 4) == 0);
         cfg_sel   = $urandom_range(0, 1);
         cfg_data  = $urandom;
         sync_clr  = ($urandom_range(0, 22) == 0);
         if (i % 200 == 0) dither_en = $urandom_range(0, 1);
         tick();
      end
      en = 0; cfg_valid = 0; sync_clr = 0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tuner_nco.md
TUNER_NCO -- requirements
Module: tuner_nco

Interface
- REQ-001: Parameter ASZ, default 32: phase accumulator width.
- REQ-002: Parameter PSZ, default 11: output phase word width (mixer phase input width).
- REQ-003: clk  input  1  sole clock; all logic on rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: en  input  1  sample strobe; accumulator advances only on cycles with en=1.
- REQ-006: cfg_valid  input  1  configuration write request.
- REQ-007: cfg_sel  input  1  write target: 0 = frequency word, 1 = phase offset.
- REQ-008: cfg_data  input  ASZ  write data; phase offset uses cfg_data[PSZ-1:0].
- REQ-009: cfg_ready  output  1  write accepted when cfg_valid and cfg_ready are both 1.
- REQ-010: sync_clr  input  1  request to zero the accumulator at the next strobe.
- REQ-011: dither_en  input  1  enables phase dither.
- REQ-012: phs  output  PSZ  output phase word.
- REQ-013: phs_valid  output  1  one-cycle qualifier for phs.
- REQ-014: wrap  output  1  one-cycle pulse, aligned with phs_valid, marking an accumulator overflow.

Function
- REQ-015: Active registers: frequency word freq (ASZ bits), phase offset poff (PSZ bits), accumulator acc (ASZ bits).
- REQ-016: Shadow registers: one shadow register and one pending flag per target (frequency, phase offset).
- REQ-017: A handshake (cfg_valid & cfg_ready) writes the selected shadow register and sets that target's pending flag.
- REQ-018: cfg_ready = !pending of the target addressed by cfg_sel.
- REQ-019: While a target is pending, a new write to that target is stalled; it is neither dropped nor overwritten.
- REQ-020: On an en cycle, each pending shadow value is copied to its active register and its pending flag is cleared.
- REQ-021: A value applied on an en cycle takes effect from the next en cycle, not the current one.
- REQ-022: A handshake on the same cycle as en sets pending only; that value is applied at the following en.
- REQ-023: Accumulator update on an en cycle: acc <= sync_clr_pend ? 0 : acc + freq, modulo 2^ASZ.
- REQ-024: The carry-out of acc + freq is registered as the wrap source; a cleared accumulator produces no wrap.
- REQ-025: sync_clr asserted on any cycle sets sync_clr_pend; the next en consumes and clears it.
- REQ-026: sync_clr and en asserted on the same cycle clear the accumulator on that en.
- REQ-027: Stage 2 starts on the cycle after an en cycle.
- REQ-028: Stage 2 computes s = acc + {poff, (ASZ-PSZ) zeros} + d, modulo 2^ASZ.
- REQ-029: d = zero-extended lfsr[ASZ-PSZ-1:0] when dither_en=1, else 0.
- REQ-030: Stage 2 registers phs <= s[ASZ-1:ASZ-PSZ] (truncation, no rounding), phs_valid <= 1, and wrap <= registered carry.
- REQ-031: Latency: en at cycle n gives phs_valid=1 at cycle n+2 (two register stages).
- REQ-032: Back-to-back en gives one phs_valid per cycle with no bubbles.
- REQ-033: phs_valid and wrap are 0 on every cycle not derived from an en.
- REQ-034: phs holds its last value on cycles without a valid output.
- REQ-035: LFSR: 32-bit Fibonacci, taps 32,22,2,1, seed 0xACE1_0001.
- REQ-036: The LFSR advances once per en cycle, independent of dither_en.
- REQ-037: The LFSR never reaches the all-zero state.
- REQ-038: No combinational path from any input to any output except cfg_valid/cfg_sel -> cfg_ready.

Reset
- REQ-039: On reset_n=0, immediately and without waiting for a clock edge: freq, poff, acc, shadows, pending flags, sync_clr_pend and the pipeline registers clear to 0.
- REQ-040: On reset_n=0: phs=0, phs_valid=0, wrap=0, cfg_ready=1, and the LFSR loads its seed.
- REQ-041: Reset asserted mid-operation discards pending writes and in-flight stage data; no phs_valid is emitted for them.
- REQ-042: After reset_n deasserts, the first output requires an en.

Verification
- REQ-043: Write freq=0x2000_0000, then en held high, dither off -> phs sequence 0x000,0x100,...,0x700,0x000 repeating; wrap=1 with each 0x000 after the first.
- REQ-044: Write poff=0x200 mid-stream with freq=0x2000_0000 -> after the next en, phs steps by +0x200 (e.g. 0x300 becomes 0x500); no samples skipped.
- REQ-045: Second write to freq while the first is pending with en low -> cfg_ready=0 (for cfg_sel=0) until en; the first value is applied, then the second is accepted.
- REQ-046: sync_clr pulse while en is low, freq=0x1000_0000 -> the next en yields phs=0x000 with wrap=0, then 0x080, 0x100.
- REQ-047: freq=0, dither_en=1, poff=0 -> phs toggles only between 0x000 and 0x7FF or 0x000 and 0x001 pattern, never beyond ±1 LSB.
- REQ-048: Assert reset_n=0 for 1 cycle mid-stream with a write pending -> outputs zero asynchronously; after release with en high, phs stays 0x000 (freq=0).
